// File: rtl/mux_bank_reg.sv
// mux_bank_reg: registered multi-lane source multiplexer with a valid/ready
// output stage. Each capture loads every lane of one source into y. That
// source is either the selector input (direct mode) or an internal scan
// counter that steps through the sources one capture at a time (scan mode).
//
// Optional feature: define MUX_BANK_PARITY_EN to add out_parity, a per-lane
// even-parity word that is captured alongside y.
//
// Handshake: an input transfer (capture) happens on a rising edge where
// in_valid && in_ready. An output transfer (drain) happens on a rising edge
// where out_valid && out_ready. in_ready is high whenever the output register
// is empty or is being drained in the same cycle. A capture and a drain can
// therefore occur on the same edge. y/out_src stay stable while
// out_valid && !out_ready.
module mux_bank_reg #(
    parameter  int WIDTH   = 1,
    parameter  int LANES   = 4,
    parameter  int SOURCES = 4,
    localparam int SEL_W   = $clog2(SOURCES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SOURCES*LANES*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]               selector,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [LANES*WIDTH-1:0]         y,
    output logic [SEL_W-1:0]               out_src,
    output logic                           out_valid,
    input  logic                           out_ready
`ifdef MUX_BANK_PARITY_EN
    ,
    output logic [LANES-1:0]               out_parity
`endif
);

    logic [SEL_W-1:0]       scan_cnt;
    logic [SEL_W-1:0]       eff_src;
    logic [LANES*WIDTH-1:0] sel_word;
    logic                   capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // Pick the effective source index and clamp out-of-range values to the last source.
    always_comb begin
        eff_src = mode ? scan_cnt : selector;
        if (int'(eff_src) > SOURCES - 1) begin
            eff_src = SEL_W'(SOURCES - 1);
        end
    end

    // Gather all lanes of the effective source; a source's lanes are contiguous in data_in.
    always_comb begin
        sel_word = '0;
        for (int s = 0; s < SOURCES; s++) begin
            if (eff_src == SEL_W'(s)) begin
                sel_word = data_in[s*LANES*WIDTH +: LANES*WIDTH];
            end
        end
    end

    // Output register: load on capture, empty on a drain without capture, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            y         <= sel_word;
            out_src   <= eff_src;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Scan counter: held at 0 outside scan mode so each scan starts at source 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (!mode) begin
            scan_cnt <= '0;
        end else if (capture) begin
            if (scan_cnt >= SEL_W'(SOURCES - 1)) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + SEL_W'(1);
            end
        end
    end

`ifdef MUX_BANK_PARITY_EN
    logic [LANES-1:0] sel_parity;

    // Even parity (XOR reduction) of each lane of the selected source.
    always_comb begin
        sel_parity = '0;
        for (int l = 0; l < LANES; l++) begin
            sel_parity[l] = ^sel_word[l*WIDTH +: WIDTH];
        end
    end

    // Parity register follows the same load/hold rules as y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_parity <= '0;
        end else if (capture) begin
            out_parity <= sel_parity;
        end
    end
`endif

endmodule

// File: tb/tb_mux_bank_reg.sv
// tb_mux_bank_reg: directed test of mux_bank_reg with WIDTH=4, LANES=4,
// SOURCES=4. Source s lane l carries 4'h(4*s+l), so the data_in bus is
// 64'hFEDCBA9876543210. Source words seen on y are:
// s0=16'h3210, s1=16'h7654, s2=16'hBA98, s3=16'hFEDC.
module tb_mux_bank_reg;

    localparam int WIDTH   = 4;
    localparam int LANES   = 4;
    localparam int SOURCES = 4;
    localparam int SEL_W   = 2;

    // ---------------- clock / reset ----------------
    logic                           clk;
    logic                           rst;
    logic [SOURCES*LANES*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]               selector;
    logic                           mode;
    logic                           in_valid;
    logic                           in_ready;
    logic [LANES*WIDTH-1:0]         y;
    logic [SEL_W-1:0]               out_src;
    logic                           out_valid;
    logic                           out_ready;
`ifdef MUX_BANK_PARITY_EN
    logic [LANES-1:0]               out_parity;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mux_bank_reg #(
        .WIDTH   (WIDTH),
        .LANES   (LANES),
        .SOURCES (SOURCES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .selector  (selector),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_BANK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] src_word [4];
    logic [1:0]  bp_sel   [3];
    logic [1:0]  scan_exp [6];

    initial begin
        src_word = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        bp_sel   = '{2'd0, 2'd1, 2'd3};
        scan_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst       = 1'b1;
        data_in   = 64'hFEDCBA9876543210;
        selector  = 2'd2;
        mode      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;

        // Reset state, before any clock edge.
        #1;
        check("rst_y", 32'(y), 32'h0);
        check("rst_src", 32'(out_src), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // No capture on an edge while reset is held.
        tick();
        check("rst_edge_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;

        // Direct mode capture of source 2.
        tick();
        check("direct_y", 32'(y), 32'hBA98);
        check("direct_src", 32'(out_src), 32'h2);
        check("direct_valid", 32'(out_valid), 32'h1);

        // Back-pressure: output must hold while selector moves.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            selector = bp_sel[i];
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("bp_y", 32'(y), 32'hBA98);
            check("bp_src", 32'(out_src), 32'h2);
            check("bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        check("drain_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("drain_valid", 32'(out_valid), 32'h0);

        // Simultaneous capture and drain.
        in_valid = 1'b1;
        selector = 2'd0;
        tick();
        check("sim_pre_y", 32'(y), 32'h3210);
        check("sim_pre_valid", 32'(out_valid), 32'h1);
        selector = 2'd3;
        #1;
        check("sim_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("sim_valid", 32'(out_valid), 32'h1);
        check("sim_y", 32'(y), 32'hFEDC);
        check("sim_src", 32'(out_src), 32'h3);

        // Scan mode: sequence wraps 0,1,2,3,0,1.
        mode     = 1'b1;
        selector = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("scan_src", 32'(out_src), 32'(scan_exp[i]));
            check("scan_y", 32'(y), 32'(src_word[scan_exp[i]]));
        end

        // One direct cycle resets the scan position.
        mode = 1'b0;
        tick();
        check("scan_direct_src", 32'(out_src), 32'h2);
        mode = 1'b1;
        tick();
        check("scan_restart_src", 32'(out_src), 32'h0);
        tick();
        check("scan_step_src", 32'(out_src), 32'h1);
        check("scan_step_y", 32'(y), 32'h7654);
`ifdef MUX_BANK_PARITY_EN
        check("parity_sel1", 32'(out_parity), 32'b1001);
`endif

        // Asynchronous reset between edges while holding a result
        // (scan counter is at 2 here).
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("pre_arst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_y", 32'(y), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_src", 32'(out_src), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h1);
`ifdef MUX_BANK_PARITY_EN
        check("arst_parity", 32'(out_parity), 32'h0);
`endif
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_edge_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;

        // Scan restarts from source 0 after reset.
        tick();
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_src", 32'(out_src), 32'h0);
        check("post_rst_y", 32'(y), 32'h3210);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_bank_reg.md
MUX_BANK_REG -- requirements
Module: mux_bank_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 1, bits per lane.
REQ-002 SHALL have parameter LANES, default 4, number of output lanes.
REQ-003 SHALL have parameter SOURCES, default 4, number of selectable sources (2..16).
REQ-004 SHALL have localparam SEL_W, value clog2(SOURCES), selector width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port data_in, input, SOURCES*LANES*WIDTH, flat bus; source s lane l at bits (s*LANES+l)*WIDTH +: WIDTH.
REQ-008 SHALL have port selector, input, SEL_W, source index used in direct mode.
REQ-009 SHALL have port mode, input, 1, 0 = direct, 1 = scan.
REQ-010 SHALL have port in_valid, input, 1, data_in/selector valid this cycle.
REQ-011 SHALL have port in_ready, output, 1, block can accept a capture this cycle.
REQ-012 SHALL have port y, output, LANES*WIDTH, registered lane outputs; lane l at bits l*WIDTH +: WIDTH.
REQ-013 SHALL have port out_src, output, SEL_W, index of the source held in y.
REQ-014 SHALL have port out_valid, output, 1, y/out_src hold an unconsumed result.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts y this cycle.

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL perform a capture when in_valid && in_ready: y loads all LANES of the effective source, out_src loads that index, and out_valid goes to 1 on the next edge (latency 1).
REQ-018 SHALL use effective source = selector in direct mode and scan counter in scan mode.
REQ-019 SHALL treat an effective source >= SOURCES as SOURCES-1.
REQ-020 SHALL clear out_valid on out_valid && out_ready with no capture; when capture and drain occur in the same cycle, out_valid stays 1 and new data is loaded.
REQ-021 SHALL hold y, out_src and out_valid unchanged while out_valid && !out_ready (back-pressure).
REQ-022 SHALL increment the scan counter by 1 on each capture in scan mode, wrapping from SOURCES-1 to 0.
REQ-023 SHALL force the scan counter to 0 on every cycle with mode = 0, so scan always starts at source 0.
REQ-024 SHALL sample a mode change in the same cycle as a capture; the capture uses the new mode.

Reset
REQ-025 SHALL on rst = 1 immediately clear y, out_src, out_valid and the scan counter to 0, independent of clk.
REQ-026 SHALL drop any held result on reset mid-operation; in_ready reads 1 while in reset.
REQ-027 SHALL perform no capture on the first edge at which rst is high; captures resume on the first edge after deassertion.

Configuration
REQ-028 SHALL, with MUX_BANK_PARITY_EN defined, add output port out_parity, LANES bits, where bit l is the even parity (XOR) of lane l, registered on each capture, cleared by reset, and held under back-pressure.
REQ-029 SHALL, without MUX_BANK_PARITY_EN, omit out_parity and all parity logic; other behaviour is identical.

Verification (WIDTH=4, LANES=4, SOURCES=4; source s lane l = 4'h(4*s+l) unless stated)
REQ-030 SHALL verify direct mode: mode=0, selector=2, in_valid=1, out_ready=1 -> next cycle y=16'hBA98, out_src=2, out_valid=1.
REQ-031 SHALL verify back-pressure: after a capture, out_ready=0 for 3 cycles with changing selector -> in_ready=0, y/out_src unchanged; out_ready=1 -> out_valid=0 next cycle if in_valid=0.
REQ-032 SHALL verify scan wrap: mode=1, in_valid=1, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1; mode=0 for 1 cycle then mode=1 -> next out_src=0.
REQ-033 SHALL verify simultaneous events: out_valid=1, out_ready=1, in_valid=1 with selector=3 -> out_valid stays 1, y=16'hFEDC.
REQ-034 SHALL verify asynchronous reset: assert rst between edges while out_valid=1 -> y=0, out_valid=0, out_src=0 before the next edge.
REQ-035 SHALL verify, with MUX_BANK_PARITY_EN defined, selector=1 (lanes 4,5,6,7) -> out_parity=4'b1001.
